su_adder_v2: RTL and testbench

//  Spatial-unrolling reducer between the PE array and the psum GBF BRAM, successor of v1.
//  - Sums each row's groups of irrel_num adjacent PE psums, packs results into GBF words and writes them to BRAM.
//  - Walks every psum RF address.
//  - Generalises v1 with runtime BRAM base address, cross-row lane packing and a config-error path.
//  - Adds an optional saturating output stage.

---
 rtl/su_adder_pkg.sv | 35 +++
 rtl/su_adder_v2_if.sv | 40 ++++
 rtl/su_group_reducer.sv | 59 +++++
 rtl/su_adder_v2.sv | 184 ++++++++++++++++++
 tb/tb_su_adder_v2.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/su_adder_pkg.sv
// su_adder_pkg: shared state encoding, default geometry and helpers
// for the su_adder_v2 spatial-unrolling reducer.
package su_adder_pkg;

    localparam int DEF_ROW   = 16;
    localparam int DEF_COL   = 16;
    localparam int DEF_DW    = 16;
    localparam int DEF_GBF   = 512;
    localparam int DEF_RFW   = 2;
    localparam int DEF_BAW   = 10;
    localparam int DEF_IRW   = 5;

    localparam int LANES = DEF_GBF / DEF_DW;
    localparam int DEPTH = 2 ** DEF_RFW;

    function automatic int su_clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++)
            if ((1 << i) < v) r = i + 1;
        return r;
    endfunction

    localparam int ACC_W = DEF_DW + su_clog2(DEF_COL);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_ROW,
        S_FLUSH,
        S_DONE,
        S_ERR
    } state_t;

endpackage

// File: rtl/su_adder_v2_if.sv
// su_adder_v2_if: PE-array side inputs and psum GBF write-side outputs
// of the su_adder_v2 reducer.
interface su_adder_v2_if #(
    parameter int ROW                   = 16,
    parameter int COL                   = 16,
    parameter int DATA_BITWIDTH         = 16,
    parameter int GBF_DATA_BITWIDTH     = 512,
    parameter int PSUM_RF_ADDR_BITWIDTH = 2,
    parameter int BRAM_ADDR_BITWIDTH    = 10,
    parameter int IRREL_BITWIDTH        = 5
);

    logic [DATA_BITWIDTH*ROW*COL-1:0] psum_out;
    logic                             pe_psum_finish;
    logic                             conv_finish;
    logic [IRREL_BITWIDTH-1:0]        irrel_num;
    logic [BRAM_ADDR_BITWIDTH-1:0]    bram_base;

    logic [PSUM_RF_ADDR_BITWIDTH-1:0] psum_rf_addr;
    logic [GBF_DATA_BITWIDTH-1:0]     out_data;
    logic                             psum_write_en;
    logic [BRAM_ADDR_BITWIDTH-1:0]    psum_BRAM_addr;
    logic                             psum_last;
    logic                             su_add_finish;
    logic                             cfg_err;
    logic                             busy;

    modport master (
        output psum_out, pe_psum_finish, conv_finish, irrel_num, bram_base,
        input  psum_rf_addr, out_data, psum_write_en, psum_BRAM_addr,
        input  psum_last, su_add_finish, cfg_err, busy
    );

    modport slave (
        input  psum_out, pe_psum_finish, conv_finish, irrel_num, bram_base,
        output psum_rf_addr, out_data, psum_write_en, psum_BRAM_addr,
        output psum_last, su_add_finish, cfg_err, busy
    );

endinterface

// File: rtl/su_group_reducer.sv
// su_group_reducer: sums groups of irrel adjacent psums of one PE row.
// SU_ADDER_SAT_EN selects saturation instead of two's-complement wrap.
module su_group_reducer
    import su_adder_pkg::*;
#(
    parameter int COL            = 16,
    parameter int DATA_BITWIDTH  = 16,
    parameter int IRREL_BITWIDTH = 5,
    parameter int GW             = su_clog2(COL + 1)
) (
    input  logic [COL*DATA_BITWIDTH-1:0] row_psum,
    input  logic [IRREL_BITWIDTH-1:0]    irrel,
    output logic [COL*DATA_BITWIDTH-1:0] results,
    output logic [GW-1:0]                g
);

    localparam int DW = DATA_BITWIDTH;

`ifdef SU_ADDER_SAT_EN
    localparam int AW = DW + su_clog2(COL);
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};
    localparam logic signed [AW-1:0] MINV = {{(AW-DW+1){1'b1}}, {(DW-1){1'b0}}};

    function automatic logic [DW-1:0] fit(input logic signed [AW-1:0] a);
        if (a > MAXV) return MAXV[DW-1:0];
        if (a < MINV) return MINV[DW-1:0];
        return a[DW-1:0];
    endfunction
`else
    // a wrapped sum only depends on the low DW bits of every operand
    localparam int AW = DW;

    function automatic logic [DW-1:0] fit(input logic signed [AW-1:0] a);
        return a;
    endfunction
`endif

    logic signed [AW-1:0] acc [COL];
    logic signed [DW-1:0] pe;

    always_comb begin
        g = '0;
        for (int k = 1; k <= COL; k++)
            if (irrel != '0 && k * int'(irrel) <= COL) g = GW'(k);
        results = '0;
        pe = '0;
        for (int k = 0; k < COL; k++) begin
            acc[k] = '0;
            for (int c = 0; c < COL; c++) begin
                pe = row_psum[DW*(COL-c)-1 -: DW];
                if (k < int'(g) && c >= k * int'(irrel) &&
                    c < (k + 1) * int'(irrel))
                    acc[k] = acc[k] + AW'(pe);
            end
            results[DW*(COL-k)-1 -: DW] = fit(acc[k]);
        end
    end

endmodule

// File: rtl/su_adder_v2.sv
// su_adder_v2: reduces PE-row psum groups, packs them into GBF words and
// writes them from a runtime base address. Optional macro: SU_ADDER_SAT_EN.
module su_adder_v2
    import su_adder_pkg::*;
#(
    parameter int ROW                   = DEF_ROW,
    parameter int COL                   = DEF_COL,
    parameter int DATA_BITWIDTH         = DEF_DW,
    parameter int GBF_DATA_BITWIDTH     = DEF_GBF,
    parameter int PSUM_RF_ADDR_BITWIDTH = DEF_RFW,
    parameter int BRAM_ADDR_BITWIDTH    = DEF_BAW,
    parameter int IRREL_BITWIDTH        = DEF_IRW
) (
    input logic          clk,
    input logic          reset,
    su_adder_v2_if.slave bus
);

    localparam int DW  = DATA_BITWIDTH;
    localparam int GBF = GBF_DATA_BITWIDTH;
    localparam int RFW = PSUM_RF_ADDR_BITWIDTH;
    localparam int BAW = BRAM_ADDR_BITWIDTH;
    localparam int LN  = GBF / DW;
    localparam int DP  = 2 ** RFW;
    localparam int FW  = su_clog2(LN + 1);
    localparam int GW  = su_clog2(COL + 1);
    localparam int RW  = (ROW > 1) ? su_clog2(ROW) : 1;

    state_t state, nstate;

    logic                      pf_q;
    logic [IRREL_BITWIDTH-1:0] irrel_q;
    logic                      conv_q;
    logic [RFW-1:0]            rf_addr;
    logic [FW-1:0]             fill;
    logic [BAW-1:0]            wr_addr;
    logic [RW-1:0]             r;
    logic [GBF-1:0]            pack;

    logic [GBF-1:0]            out_q;
    logic                      wen_q;
    logic [BAW-1:0]            waddr_q;
    logic                      last_q;
    logic                      fin_q;
    logic                      err_q;

    logic [COL*DW-1:0]         row_psum;
    logic [COL*DW-1:0]         res;
    logic [GW-1:0]             g;
    logic [GBF-1:0]            res_word;
    logic [GBF-1:0]            new_bits;
    logic                      start;
    logic                      cfg_bad;
    logic                      stall;
    logic                      last_addr;
    logic                      do_write;

    always_comb begin
        row_psum = '0;
        for (int i = 0; i < ROW; i++)
            if (r == RW'(i))
                row_psum = bus.psum_out[DW*(ROW*COL-i*COL)-1 -: COL*DW];
    end

    su_group_reducer #(
        .COL            (COL),
        .DATA_BITWIDTH  (DW),
        .IRREL_BITWIDTH (IRREL_BITWIDTH),
        .GW             (GW)
    ) u_reducer (
        .row_psum (row_psum),
        .irrel    (irrel_q),
        .results  (res),
        .g        (g)
    );

    // results land MSB-first, so shifting right moves them to lane `fill`
    always_comb begin
        res_word = '0;
        res_word[GBF-1 -: COL*DW] = res;
        new_bits = res_word >> (int'(fill) * DW);
    end

    assign start     = bus.pe_psum_finish && !pf_q;
    assign cfg_bad   = (bus.irrel_num == '0) || (int'(bus.irrel_num) > COL);
    assign stall     = (int'(fill) + int'(g)) > LN;
    assign last_addr = (rf_addr == RFW'(DP - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= nstate;
    end

    always_comb begin
        nstate   = state;
        do_write = 1'b0;
        unique case (state)
            S_IDLE: if (start) nstate = cfg_bad ? S_ERR : S_WAIT;
            S_WAIT: nstate = S_ROW;
            S_ROW: begin
                if (stall)                       do_write = 1'b1;
                else if (r == RW'(ROW - 1))      nstate = S_FLUSH;
            end
            S_FLUSH: begin
                do_write = (fill != '0);
                nstate   = last_addr ? S_DONE : S_WAIT;
            end
            S_DONE:  nstate = S_IDLE;
            S_ERR:   nstate = S_IDLE;
            default: nstate = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pf_q    <= 1'b0;
            irrel_q <= '0;
            conv_q  <= 1'b0;
            rf_addr <= '0;
            fill    <= '0;
            wr_addr <= '0;
            r       <= '0;
            pack    <= '0;
            out_q   <= '0;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            last_q  <= 1'b0;
            fin_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            pf_q   <= bus.pe_psum_finish;
            wen_q  <= do_write;
            last_q <= 1'b0;
            fin_q  <= 1'b0;
            if (do_write) begin
                out_q   <= pack;
                waddr_q <= wr_addr;
                wr_addr <= wr_addr + BAW'(1);
                pack    <= '0;
                fill    <= '0;
                last_q  <= conv_q && (state == S_FLUSH) && last_addr;
            end
            case (state)
                S_IDLE: begin
                    if (start) begin
                        irrel_q <= bus.irrel_num;
                        conv_q  <= bus.conv_finish;
                        wr_addr <= bus.bram_base;
                        rf_addr <= '0;
                        fill    <= '0;
                        pack    <= '0;
                        r       <= '0;
                        err_q   <= 1'b0;
                    end
                end
                S_WAIT: r <= '0;
                S_ROW: begin
                    if (!stall) begin
                        pack <= pack | new_bits;
                        fill <= fill + FW'(g);
                        r    <= r + RW'(1);
                    end
                end
                S_FLUSH: if (!last_addr) rf_addr <= rf_addr + RFW'(1);
                S_DONE:  fin_q <= 1'b1;
                S_ERR: begin
                    fin_q <= 1'b1;
                    err_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.psum_rf_addr   = rf_addr;
    assign bus.out_data       = out_q;
    assign bus.psum_write_en  = wen_q;
    assign bus.psum_BRAM_addr = waddr_q;
    assign bus.psum_last      = last_q;
    assign bus.su_add_finish  = fin_q;
    assign bus.cfg_err        = err_q;
    assign bus.busy           = (state != S_IDLE);

endmodule

// File: tb/tb_su_adder_v2.sv
// tb_su_adder_v2: scoreboard bench for su_adder_v2; define SU_ADDER_SAT_EN
// on both RTL and bench to exercise the saturating variant.
`timescale 1ns/1ps
module tb_su_adder_v2;

    localparam int ROW = 16;
    localparam int COL = 16;
    localparam int DW  = 16;
    localparam int GBF = 512;
    localparam int BAW = 10;
    localparam int LN  = GBF / DW;

    typedef struct {
        logic [GBF-1:0] data;
        logic [BAW-1:0] addr;
        logic           last;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    su_adder_v2_if bus ();

    su_adder_v2 dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    exp_t q[$];
    int   compared    = 0;
    int   mismatched  = 0;
    int   cyc         = 0;
    int   last_wr_cyc = -1;
    int   fin_cyc     = -1;
    int   job_writes  = 0;
    bit   fin_seen    = 1'b0;

    logic [DW-1:0] vrows [ROW] = '{1, 1, 1, 2, 2, 2, 3, 3, 3, 4, 4, 4, 5, 5, 5, 0};
    logic [DW-1:0] res3  [ROW] = '{3, 3, 3, 6, 6, 6, 9, 9, 9, 12, 12, 12, 15, 15, 15, 0};
    logic [DW-1:0] res7  [ROW] = '{7, 7, 7, 14, 14, 14, 21, 21, 21, 28, 28, 28, 35, 35, 35, 0};
    logic [DW-1:0] res16 [ROW] = '{16, 16, 16, 32, 32, 32, 48, 48, 48, 64, 64, 64, 80, 80, 80, 0};
    logic [DW-1:0] vmax  [ROW];
    logic [DW-1:0] vmin  [ROW];
    logic [DW-1:0] rmax  [ROW];
    logic [DW-1:0] rmin  [ROW];

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [GBF-1:0] act,
                         input logic [GBF-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // monitor: pops the scoreboard on every write strobe
    always @(negedge clk) begin
        exp_t e;
        if (!reset && bus.psum_write_en) begin
            job_writes++;
            last_wr_cyc = cyc;
            check("wr_expected", GBF'(q.size() != 0), GBF'(1));
            if (q.size() != 0) begin
                e = q.pop_front();
                check("wr_data", bus.out_data, e.data);
                check("wr_addr", GBF'(bus.psum_BRAM_addr), GBF'(e.addr));
                check("wr_last", GBF'(bus.psum_last), GBF'(e.last));
            end
        end
        if (!reset && bus.su_add_finish) begin
            fin_seen = 1'b1;
            fin_cyc  = cyc;
        end
    end

    task automatic set_psum(input logic [DW-1:0] v [ROW], input bit junk);
        for (int r = 0; r < ROW; r++)
            for (int c = 0; c < COL; c++)
                bus.psum_out[DW*(ROW*COL-r*COL-c)-1 -: DW] =
                    (junk && c == COL - 1) ? 16'h1234 : v[r];
    endtask

    task automatic push_job(input logic [DW-1:0] res [ROW], input int g,
                            input logic [BAW-1:0] base, input logic conv);
        logic [GBF-1:0] w;
        logic [BAW-1:0] a;
        int             fill;
        a = base;
        for (int ad = 0; ad < 4; ad++) begin
            w    = '0;
            fill = 0;
            for (int r = 0; r < ROW; r++) begin
                if (fill + g > LN) begin
                    q.push_back(exp_t'{data: w, addr: a, last: 1'b0});
                    a++;
                    w    = '0;
                    fill = 0;
                end
                for (int k = 0; k < g; k++)
                    w[GBF-1-(fill+k)*DW -: DW] = res[r];
                fill += g;
            end
            q.push_back(exp_t'{data: w, addr: a, last: (conv && ad == 3)});
            a++;
        end
    endtask

    task automatic start_job(input int irrel, input logic [BAW-1:0] base,
                             input logic conv);
        fin_seen    = 1'b0;
        job_writes  = 0;
        last_wr_cyc = -1;
        @(negedge clk);
        bus.irrel_num      = 5'(irrel);
        bus.bram_base      = base;
        bus.conv_finish    = conv;
        bus.pe_psum_finish = 1'b1;
        @(negedge clk);
        check("busy_at_start", GBF'(bus.busy), GBF'(1));
        check("cfg_err_cleared", GBF'(bus.cfg_err), GBF'(0));
        @(negedge clk);
        bus.pe_psum_finish = 1'b0;
    endtask

    task automatic run_job(input int irrel, input logic [BAW-1:0] base,
                           input logic conv, input bit bad);
        start_job(irrel, base, conv);
        for (int i = 0; i < 3000 && !fin_seen; i++) @(negedge clk);
        check("finish_seen", GBF'(fin_seen), GBF'(1));
        check("queue_drained", GBF'(q.size()), GBF'(0));
        check("cfg_err", GBF'(bus.cfg_err), GBF'(bad));
        if (bad) check("err_writes", GBF'(job_writes), GBF'(0));
        else     check("finish_after_write", GBF'(fin_cyc - last_wr_cyc), GBF'(1));
        @(negedge clk);
        check("idle_after", GBF'(bus.busy), GBF'(0));
        q.delete();
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_busy"}, GBF'(bus.busy), GBF'(0));
        check({tag, "_wen"}, GBF'(bus.psum_write_en), GBF'(0));
        check({tag, "_data"}, bus.out_data, GBF'(0));
        check({tag, "_addr"}, GBF'(bus.psum_BRAM_addr), GBF'(0));
        check({tag, "_rf"}, GBF'(bus.psum_rf_addr), GBF'(0));
        check({tag, "_flags"},
              GBF'({bus.psum_last, bus.su_add_finish, bus.cfg_err}), GBF'(0));
    endtask

    initial begin
        for (int r = 0; r < ROW; r++) begin
            vmax[r] = 16'h7FFF;
            vmin[r] = 16'h8000;
`ifdef SU_ADDER_SAT_EN
            rmax[r] = 16'h7FFF;
            rmin[r] = 16'h8000;
`else
            rmax[r] = 16'hFFFE;
            rmin[r] = 16'h0000;
`endif
        end
        bus.psum_out       = '0;
        bus.pe_psum_finish = 1'b0;
        bus.conv_finish    = 1'b0;
        bus.irrel_num      = '0;
        bus.bram_base      = '0;
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;

        set_psum(vrows, 1'b1);
        push_job(res3, 5, 10'h000, 1'b0);
        run_job(3, 10'h000, 1'b0, 1'b0);

        push_job(res7, 2, 10'h010, 1'b1);
        run_job(7, 10'h010, 1'b1, 1'b0);

        set_psum(vrows, 1'b0);
        push_job(res16, 1, 10'h3FE, 1'b1);
        run_job(16, 10'h3FE, 1'b1, 1'b0);

        set_psum(vmax, 1'b0);
        push_job(rmax, 8, 10'h100, 1'b0);
        run_job(2, 10'h100, 1'b0, 1'b0);

        set_psum(vmin, 1'b0);
        push_job(rmin, 8, 10'h200, 1'b1);
        run_job(2, 10'h200, 1'b1, 1'b0);

        run_job(0, 10'h000, 1'b0, 1'b1);
        run_job(17, 10'h000, 1'b1, 1'b1);

        set_psum(vrows, 1'b1);
        push_job(res3, 5, 10'h040, 1'b1);
        start_job(3, 10'h040, 1'b1);
        for (int i = 0; i < 500 && bus.psum_rf_addr != 2'd1; i++) @(negedge clk);
        check("reached_rf1", GBF'(bus.psum_rf_addr), GBF'(1));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        q.delete();
        @(posedge clk);
        #1;
        check_zero_outputs("midreset");
        repeat (3) begin
            @(negedge clk);
            check("no_write_in_reset", GBF'(bus.psum_write_en), GBF'(0));
        end
        reset = 1'b0;

        set_psum(vrows, 1'b0);
        push_job(res16, 1, 10'h020, 1'b1);
        run_job(16, 10'h020, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
